// File: rtl/std_fifo_ex_if.sv
// Stream-side bundle of the parametrised single-clock FIFO: producer/consumer controls,
// read data, occupancy and sticky error flags.
interface std_fifo_ex_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             i_clear;
    logic             i_push;
    logic [WIDTH-1:0] i_data;
    logic             i_pop;
    logic [WIDTH-1:0] o_data;
    logic             o_empty;
    logic             o_almost_empty;
    logic             o_almost_full;
    logic             o_full;
    logic [CW-1:0]    o_word_count;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_clear, i_push, i_data, i_pop,
        input  o_data, o_empty, o_almost_empty, o_almost_full, o_full,
        input  o_word_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_clear, i_push, i_data, i_pop,
        output o_data, o_empty, o_almost_empty, o_almost_full, o_full,
        output o_word_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/std_fifo_ex.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty thresholds,
// FWFT or registered read, and sticky overflow/underflow flags.
module std_fifo_ex #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 8,
    parameter int AF_THRESHOLD = DEPTH - 1,
    parameter int AE_THRESHOLD = 1,
    parameter bit FWFT         = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    std_fifo_ex_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_wr_en;
    logic w_rd_en;

    // Pointers wrap explicitly at DEPTH-1 so any depth works, not just powers of two.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push_ok = bus.i_push && !w_full;
    assign w_pop_ok  = bus.i_pop && !w_empty;
    assign w_wr_en   = w_push_ok && !bus.i_clear;
    assign w_rd_en   = w_pop_ok && !bus.i_clear;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.i_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_rd_en) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_en && !w_wr_en) begin
                r_count <= r_count - CW'(1);
            end
            if (bus.i_push && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.i_pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.o_data = r_mem[r_rd_ptr];
        end else begin : g_reg
            logic [WIDTH-1:0] r_rdata;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_rdata <= '0;
                end else if (bus.i_clear) begin
                    r_rdata <= '0;
                end else if (w_rd_en) begin
                    r_rdata <= r_mem[r_rd_ptr];
                end
            end

            assign bus.o_data = r_rdata;
        end
    endgenerate

    assign bus.o_empty        = w_empty;
    assign bus.o_full         = w_full;
    assign bus.o_almost_empty = (r_count <= CW'(AE_THRESHOLD));
    assign bus.o_almost_full  = (r_count >= CW'(AF_THRESHOLD));
    assign bus.o_word_count   = r_count;
    assign bus.o_overflow     = r_overflow;
    assign bus.o_underflow    = r_underflow;
endmodule

// File: tb/tb_std_fifo_ex.sv
// Drives an FWFT and a registered-read FIFO with identical stimulus and checks both
// against a queue-based reference model.
module tb_std_fifo_ex;
    localparam int W  = 8;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         push;
    logic         pop;
    logic [W-1:0] din;

    int n_total;
    int n_bad;

    logic [W-1:0] q[$];
    logic         m_ov;
    logic         m_un;
    logic [W-1:0] m_rreg;

    std_fifo_ex_if #(.WIDTH(W), .DEPTH(D)) bus_a ();
    std_fifo_ex_if #(.WIDTH(W), .DEPTH(D)) bus_b ();

    assign bus_a.i_clear = clear;
    assign bus_a.i_push  = push;
    assign bus_a.i_pop   = pop;
    assign bus_a.i_data  = din;
    assign bus_b.i_clear = clear;
    assign bus_b.i_push  = push;
    assign bus_b.i_pop   = pop;
    assign bus_b.i_data  = din;

    std_fifo_ex #(.WIDTH(W), .DEPTH(D), .AF_THRESHOLD(AF), .AE_THRESHOLD(AE), .FWFT(1'b1)) u_fwft (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a)
    );

    std_fifo_ex #(.WIDTH(W), .DEPTH(D), .AF_THRESHOLD(AF), .AE_THRESHOLD(AE), .FWFT(1'b0)) u_reg (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov   = 1'b0;
        m_un   = 1'b0;
        m_rreg = '0;
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ":a_count"}, 32'(bus_a.o_word_count), 32'(sz));
        chk({tag, ":b_count"}, 32'(bus_b.o_word_count), 32'(sz));
        chk({tag, ":a_empty"}, 32'(bus_a.o_empty), 32'(sz == 0));
        chk({tag, ":a_full"}, 32'(bus_a.o_full), 32'(sz == D));
        chk({tag, ":a_ae"}, 32'(bus_a.o_almost_empty), 32'(sz <= AE));
        chk({tag, ":a_af"}, 32'(bus_a.o_almost_full), 32'(sz >= AF));
        chk({tag, ":b_full"}, 32'(bus_b.o_full), 32'(sz == D));
        chk({tag, ":a_ovf"}, 32'(bus_a.o_overflow), 32'(m_ov));
        chk({tag, ":a_unf"}, 32'(bus_a.o_underflow), 32'(m_un));
        chk({tag, ":b_ovf"}, 32'(bus_b.o_overflow), 32'(m_ov));
        chk({tag, ":b_unf"}, 32'(bus_b.o_underflow), 32'(m_un));
        chk({tag, ":b_data"}, 32'(bus_b.o_data), 32'(m_rreg));
        if (sz != 0) begin
            chk({tag, ":a_data"}, 32'(bus_a.o_data), 32'(q[0]));
        end
    endtask

    // One clock of stimulus; the model applies the acceptance rules to the pre-edge occupancy.
    task automatic step(input string tag, input logic c, input logic pu, input logic [W-1:0] d,
                        input logic po);
        bit push_ok;
        bit pop_ok;
        clear = c;
        push  = pu;
        din   = d;
        pop   = po;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            push_ok = pu && (q.size() < D);
            pop_ok  = po && (q.size() > 0);
            if (pop_ok) begin
                m_rreg = q.pop_front();
            end
            if (push_ok) begin
                q.push_back(d);
            end
            if (pu && !push_ok) m_ov = 1'b1;
            if (po && !pop_ok) m_un = 1'b1;
        end
        #1;
        clear = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        check_all(tag);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        clear   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        din     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        step("fill3_1", 1'b0, 1'b1, 8'hC1, 1'b0);
        step("fill3_2", 1'b0, 1'b1, 8'hC2, 1'b0);
        step("fill3_3", 1'b0, 1'b1, 8'hC3, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;

        step("push11", 1'b0, 1'b1, 8'h11, 1'b0);
        step("push22", 1'b0, 1'b1, 8'h22, 1'b0);
        step("push33", 1'b0, 1'b1, 8'h33, 1'b0);
        step("push44", 1'b0, 1'b1, 8'h44, 1'b0);
        step("push55", 1'b0, 1'b1, 8'h55, 1'b0);
        for (int i = 0; i < D; i++) begin
            step("drain", 1'b0, 1'b0, 8'h00, 1'b1);
        end
        step("refill11", 1'b0, 1'b1, 8'h11, 1'b0);
        step("refill22", 1'b0, 1'b1, 8'h22, 1'b0);
        step("refill33", 1'b0, 1'b1, 8'h33, 1'b0);
        step("refill44", 1'b0, 1'b1, 8'h44, 1'b0);
        step("refill55", 1'b0, 1'b1, 8'h55, 1'b0);
        step("full_pushpop", 1'b0, 1'b1, 8'h66, 1'b1);
        step("ovf_sticky", 1'b0, 1'b0, 8'h00, 1'b0);
        step("clear1", 1'b1, 1'b0, 8'h00, 1'b0);

        step("empty_pushpop", 1'b0, 1'b1, 8'hA5, 1'b1);
        step("empty_hold", 1'b0, 1'b0, 8'h00, 1'b0);
        step("clear2", 1'b1, 1'b0, 8'h00, 1'b0);

        step("push01", 1'b0, 1'b1, 8'h01, 1'b0);
        step("push02", 1'b0, 1'b1, 8'h02, 1'b0);
        step("pop1", 1'b0, 1'b0, 8'h00, 1'b1);
        step("pop2", 1'b0, 1'b0, 8'h00, 1'b1);
        step("pop3_empty", 1'b0, 1'b0, 8'h00, 1'b1);
        step("clear3", 1'b1, 1'b0, 8'h00, 1'b0);

        step("pre_clr1", 1'b0, 1'b1, 8'h31, 1'b0);
        step("pre_clr2", 1'b0, 1'b1, 8'h32, 1'b0);
        step("pre_clr3", 1'b0, 1'b1, 8'h33, 1'b0);
        step("clr_pushpop", 1'b1, 1'b1, 8'hEE, 1'b1);
        step("post_clr77", 1'b0, 1'b1, 8'h77, 1'b0);
        step("post_clr88", 1'b0, 1'b1, 8'h88, 1'b0);
        step("post_pop1", 1'b0, 1'b0, 8'h00, 1'b1);
        step("post_pop2", 1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/std_fifo_ex.md
Name: std_fifo_ex

Overview:
- Parametrised single-clock FIFO: the next generation of the standard FIFO used as a stream buffer between producer and consumer logic.
- Adds configurable width and depth, including non-power-of-two depths.
- Adds programmable almost-full and almost-empty thresholds.
- Adds selectable first-word-fall-through or registered read mode.
- Adds sticky overflow and underflow error flags.

Parameters:
- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 8: number of entries, ≥2; any integer, not only a power of two.
- AF_THRESHOLD, DEPTH-1: o_almost_full asserts when word count ≥ AF_THRESHOLD; legal range 1..DEPTH.
- AE_THRESHOLD, 1: o_almost_empty asserts when word count ≤ AE_THRESHOLD; legal range 0..DEPTH-1.
- FWFT, 1: 1 = first-word-fall-through (head word visible on o_data); 0 = registered read (word appears the cycle after the pop).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_clear  input  1  synchronous flush of contents and error flags.
- i_push  input  1  write request.
- i_data  input  WIDTH  write data.
- i_pop  input  1  read request.
- o_data  output  WIDTH  read data.
- o_empty  output  1  count == 0.
- o_almost_empty  output  1  count ≤ AE_THRESHOLD.
- o_almost_full  output  1  count ≥ AF_THRESHOLD.
- o_full  output  1  count == DEPTH.
- o_word_count  output  $clog2(DEPTH+1)  number of stored words.
- o_overflow  output  1  sticky: a push was attempted while full.
- o_underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset: one clock, i_clk; reset i_rst is asynchronous and active-high.
  - While i_rst is high: write/read pointers = 0, count = 0, o_overflow = 0, o_underflow = 0, registered o_data = 0.
  - Resulting outputs: o_empty = 1, o_almost_empty = 1, o_full = 0; o_almost_full = 0 (AF_THRESHOLD ≥ 1).
  - Reset asserted mid-operation discards all contents immediately.
- Acceptance:
  - Push is accepted iff i_push && !o_full.
  - Pop is accepted iff i_pop && !o_empty.
  - Both decisions use the pre-edge state; no bypass.
  - At full with push+pop: pop accepted, push rejected.
  - At empty with push+pop: push accepted, pop rejected.
- Storage:
  - An accepted push writes mem[wr_ptr] = i_data.
  - Each pointer increments on its accepted operation and wraps from DEPTH-1 to 0; no power-of-two assumption.
- Count update, per edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
  - The count never leaves 0..DEPTH.
- Flags:
  - All four flags are combinational decodes of the registered count.
  - They therefore change one cycle after the accepted operation.
- Errors:
  - Rejected push sets o_overflow; rejected pop sets o_underflow.
  - Both are sticky until i_clear or i_rst.
  - A rejected operation changes no other state.
- Read data, FWFT = 1:
  - o_data = mem[rd_ptr] combinationally.
  - Valid whenever o_empty = 0; don't-care when empty.
  - An accepted pop consumes the displayed word.
  - First-write-to-visible latency is 1 cycle after the push edge.
- Read data, FWFT = 0:
  - o_data is a register loaded with mem[rd_ptr] on an accepted pop.
  - It holds its value otherwise, including across rejected pops.
  - Pop-to-data latency is 1 cycle.
- i_clear:
  - Has priority over push/pop in the same cycle; that cycle's push/pop are ignored and raise no error flags.
  - Next state: pointers = 0, count = 0, both error flags = 0, registered o_data = 0.
  - i_rst has priority over everything.
- Memory contents are not reset; only pointers define validity.

Test Plan (WIDTH=8, DEPTH=5, AF_THRESHOLD=4, AE_THRESHOLD=1 unless noted):
- Reset then idle:
  - o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0, o_word_count=0, o_overflow=0, o_underflow=0.
  - Assert i_rst mid-fill at count=3: count becomes 0 asynchronously, with no clock edge.
- FWFT=1, push 0x11,0x22,0x33,0x44,0x55:
  - Count steps 1..5; o_almost_empty drops when count reaches 2.
  - o_almost_full rises at count=4; o_full rises at count=5.
  - o_data=0x11 one cycle after the first push edge.
  - Pops return 0x11..0x55 in order; the pointer wraps through a non-power-of-two depth.
- At full, push 0x66 with pop in the same cycle:
  - 0x11 popped; 0x66 dropped; o_overflow=1; count=4.
  - o_overflow stays 1 until i_clear is pulsed, then 0.
- At empty, push 0xA5 with pop in the same cycle:
  - o_underflow=1, count=1.
  - FWFT=1: o_data=0xA5 next cycle.
- FWFT=0, push 0x01,0x02 then pop twice:
  - o_data=0x01 the cycle after the first pop, 0x02 after the second.
  - A third pop while empty leaves o_data=0x02 and sets o_underflow=1.
- Count=3 with i_clear+i_push+i_pop in one cycle:
  - Next cycle count=0, o_empty=1, no error flags set.
  - Later pushes start at entry 0 and read back correctly.
